// File: rtl/asm_deframer.sv
// asm_deframer
// Locks onto a 32-bit attached sync marker (ASM) in a word stream and unpacks
// the fixed-length payload that follows each marker into a byte stream.
// Lock is acquired only on an exact marker. Once locked, markers within
// ERR_TOL bit errors are accepted. A bad marker still lets its frame through
// (flywheel) until MISS_LIMIT consecutive misses drop the lock.
//
// Ports
//   core_clk       clock
//   rst            asynchronous, active-high reset
//   s_axis_tdata   framed 32-bit word stream, first byte in [31:24]
//   s_axis_tvalid  input word valid
//   s_axis_tlast   ignored
//   s_axis_tready  input word accepted when high together with tvalid
//   m_axis_tdata   payload byte
//   m_axis_tvalid  payload byte valid
//   m_axis_tlast   high on the final payload byte of a frame
//   m_axis_tready  downstream ready
//   locked         frame lock status
//   sync_err       one-cycle pulse for each rejected marker while locked
//   frame_cnt      frames emitted, wraps at 16'hFFFF

`timescale 1ns/1ps

module asm_deframer #(
    parameter logic [31:0] SYNC_MARKER = 32'h1ACFFC1D,
    parameter int          PAYLOAD_LEN = 255,
    parameter int          ERR_TOL     = 2,
    parameter int          MISS_LIMIT  = 3
) (
    input  logic        core_clk,
    input  logic        rst,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        locked,
    output logic        sync_err,
    output logic [15:0] frame_cnt
);

    // Frame geometry. The last data word carries LAST_BYTES payload bytes;
    // any remaining bytes of that word are pad and are never emitted.
    localparam int         NWORDS     = (PAYLOAD_LEN + 3) / 4;
    localparam int         LAST_BYTES = PAYLOAD_LEN - 4 * (NWORDS - 1);
    localparam logic [7:0] LAST_WORD  = 8'(NWORDS - 1);
    localparam logic [1:0] LAST_IDX   = 2'(LAST_BYTES - 1);
    localparam logic [5:0] ERR_TOL_W  = 6'(ERR_TOL);
    localparam logic [7:0] MISS_LIM_W = 8'(MISS_LIMIT);

    typedef enum logic [1:0] {SEARCH, CHECK, DATA, FLY} state_t;

    state_t      state_q, state_d;
    logic [31:0] buf_word;
    logic [1:0]  byte_idx;
    logic [1:0]  byte_last;
    logic        buf_is_last;
    logic [7:0]  word_cnt;
    logic [7:0]  miss_cnt;
    logic [7:0]  miss_next;
    logic [5:0]  bit_errs;
    logic [1:0]  next_idx;
    logic [7:0]  next_byte;
    logic        word_is_last;
    logic        buf_drain;
    logic        data_ready;
    logic        load_word;
    logic        start_frame;
    logic        lock_set;
    logic        lock_clr;
    logic        miss_clr;
    logic        miss_inc;
    logic        err_pulse;
    logic        unused_tlast;

    assign unused_tlast = s_axis_tlast;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    // Helper terms: marker distance, buffer position and the byte that
    // follows the one currently presented on m_axis.
    always_comb begin
        bit_errs     = popcount32(s_axis_tdata ^ SYNC_MARKER);
        miss_next    = miss_cnt + 8'd1;
        word_is_last = (word_cnt == LAST_WORD);
        next_idx     = byte_idx + 2'd1;
        buf_drain    = m_axis_tvalid && m_axis_tready && (byte_idx == byte_last);
        data_ready   = !m_axis_tvalid || buf_drain;
        case (next_idx)
            2'd0:    next_byte = buf_word[31:24];
            2'd1:    next_byte = buf_word[23:16];
            2'd2:    next_byte = buf_word[15:8];
            default: next_byte = buf_word[7:0];
        endcase
    end

    // Next-state logic. Marker slots (SEARCH, CHECK) never touch the unpack
    // buffer, so they accept unconditionally while the previous frame's last
    // word may still be draining.
    always_comb begin
        state_d       = state_q;
        s_axis_tready = 1'b0;
        load_word     = 1'b0;
        start_frame   = 1'b0;
        lock_set      = 1'b0;
        lock_clr      = 1'b0;
        miss_clr      = 1'b0;
        miss_inc      = 1'b0;
        err_pulse     = 1'b0;
        case (state_q)
            SEARCH: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && (s_axis_tdata == SYNC_MARKER)) begin
                    state_d     = DATA;
                    lock_set    = 1'b1;
                    start_frame = 1'b1;
                end
            end
            CHECK: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (bit_errs <= ERR_TOL_W) begin
                        state_d     = DATA;
                        miss_clr    = 1'b1;
                        start_frame = 1'b1;
                    end else begin
                        err_pulse = 1'b1;
                        miss_inc  = 1'b1;
                        if (miss_next == MISS_LIM_W) begin
                            state_d  = SEARCH;
                            lock_clr = 1'b1;
                        end else begin
                            state_d     = FLY;
                            start_frame = 1'b1;
                        end
                    end
                end
            end
            DATA, FLY: begin
                s_axis_tready = data_ready;
                if (s_axis_tvalid && data_ready) begin
                    load_word = 1'b1;
                    if (word_is_last) begin
                        state_d = CHECK;
                    end
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // State register.
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock status, miss counter and per-frame word counter. The miss counter
    // restarts from zero whenever lock is gained or lost.
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            locked   <= 1'b0;
            sync_err <= 1'b0;
            miss_cnt <= '0;
            word_cnt <= '0;
        end else begin
            sync_err <= err_pulse;
            if (lock_set) begin
                locked <= 1'b1;
            end else if (lock_clr) begin
                locked <= 1'b0;
            end
            if (miss_clr || lock_set || lock_clr) begin
                miss_cnt <= '0;
            end else if (miss_inc) begin
                miss_cnt <= miss_next;
            end
            if (start_frame) begin
                word_cnt <= '0;
            end else if (load_word) begin
                word_cnt <= word_cnt + 8'd1;
            end
        end
    end

    // Unpack buffer. The output register always shows byte byte_idx of
    // buf_word, so byte 0 is valid the cycle after the word is accepted and
    // a new word can land on the same edge the last byte is taken.
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            buf_word      <= '0;
            byte_idx      <= '0;
            byte_last     <= '0;
            buf_is_last   <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (load_word) begin
            buf_word      <= s_axis_tdata;
            byte_idx      <= 2'd0;
            byte_last     <= word_is_last ? LAST_IDX : 2'd3;
            buf_is_last   <= word_is_last;
            m_axis_tdata  <= s_axis_tdata[31:24];
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= word_is_last && (LAST_IDX == 2'd0);
        end else if (m_axis_tvalid && m_axis_tready) begin
            if (byte_idx == byte_last) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end else begin
                byte_idx     <= next_idx;
                m_axis_tdata <= next_byte;
                m_axis_tlast <= buf_is_last && (next_idx == byte_last);
            end
        end
    end

    // Frame counter, stepped on the handshake of each frame's final byte.
    always_ff @(posedge core_clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_asm_deframer.sv
// tb_asm_deframer
// Self-checking bench for asm_deframer. A table of frames (marker, payload
// seed, expected sync_err pulses, emission, lock and frame count) is played
// through the default-parameter instance; hand-written sequences cover the
// output stall pattern and a reset in the middle of a frame. A second
// instance with a one-byte payload runs 65536 frames on its own clock to
// reach the frame_cnt wrap.

`timescale 1ns/1ps

module tb_asm_deframer;

    localparam logic [31:0] SYNC = 32'h1ACFFC1D;

    typedef struct {
        logic [31:0] marker;
        logic [7:0]  seed;
        bit          b2b;
        int          exp_err;
        bit          exp_emit;
        bit          exp_locked;
        int          exp_cnt;
    } row_t;

    logic        core_clk;
    logic        rst;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
    logic        locked;
    logic        sync_err;
    logic [15:0] frame_cnt;

    logic        w_clk;
    logic        w_rst;
    logic [31:0] w_s_tdata;
    logic        w_s_tvalid;
    logic        w_s_tready;
    logic [7:0]  w_m_tdata;
    logic        w_m_tvalid;
    logic        w_m_tlast;
    logic        w_locked;
    logic        w_sync_err;
    logic [15:0] w_frame_cnt;

    int          checks;
    int          errors;
    int          err_seen;
    int          rx_count;
    bit          stall_mode;
    logic [8:0]  exp_q[$];

    asm_deframer dut (
        .core_clk      (core_clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .locked        (locked),
        .sync_err      (sync_err),
        .frame_cnt     (frame_cnt)
    );

    asm_deframer #(.PAYLOAD_LEN(1)) dut_wrap (
        .core_clk      (w_clk),
        .rst           (w_rst),
        .s_axis_tdata  (w_s_tdata),
        .s_axis_tvalid (w_s_tvalid),
        .s_axis_tlast  (1'b0),
        .s_axis_tready (w_s_tready),
        .m_axis_tdata  (w_m_tdata),
        .m_axis_tvalid (w_m_tvalid),
        .m_axis_tlast  (w_m_tlast),
        .m_axis_tready (1'b1),
        .locked        (w_locked),
        .sync_err      (w_sync_err),
        .frame_cnt     (w_frame_cnt)
    );

    initial begin
        core_clk = 1'b0;
        forever #5 core_clk = ~core_clk;
    end

    initial begin
        w_clk = 1'b0;
        forever #2 w_clk = ~w_clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name, input logic [31:0] actual);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got 0x%0h, expected no such event", name, actual);
    endtask

    // Downstream ready: always high, or high one cycle in three when stalling.
    initial begin
        int cyc;
        cyc = 0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge core_clk);
            #1;
            cyc++;
            m_axis_tready = stall_mode ? ((cyc % 3) == 0) : 1'b1;
        end
    end

    // Output monitor: scoreboard against exp_q, hold check during stalls,
    // and sync_err pulse counting.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic [8:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge core_clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_output("hold_valid", 32'(m_axis_tvalid), 32'd1);
                    check_output("hold_data", 32'(m_axis_tdata), 32'(prev_data));
                    check_output("hold_last", 32'(m_axis_tlast), 32'(prev_last));
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        report_fail("unexpected_byte", 32'(m_axis_tdata));
                    end else begin
                        e = exp_q.pop_front();
                        check_output("byte_data", 32'(m_axis_tdata), 32'(e[7:0]));
                        check_output("byte_last", 32'(m_axis_tlast), 32'(e[8]));
                    end
                    rx_count++;
                end
                if (sync_err) begin
                    err_seen++;
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
            end
        end
    end

    // Offer one word and wait (bounded) for it to be accepted. With chk_full
    // the FSM is known to be in a data state, so a held output byte must
    // keep s_axis_tready low.
    task automatic apply_stimulus(input logic [31:0] w, input bit chk_full);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        s_axis_tdata  = w;
        s_axis_tvalid = 1'b1;
        while (!done && n < 2000) begin
            @(negedge core_clk);
            if (chk_full && m_axis_tvalid && !m_axis_tready && !rst) begin
                check_output("tready_full", 32'(s_axis_tready), 32'd0);
            end
            if (s_axis_tready) begin
                done = 1'b1;
            end
            @(posedge core_clk);
            #1;
            n++;
        end
        if (!done) begin
            report_fail("input_timeout", w);
        end
    endtask

    // Marker plus 64 data words: payload byte k is k+seed, one zero pad byte.
    task automatic send_frame(input logic [31:0] marker, input logic [7:0] seed,
                              input bit emit, input bit chk_full);
        logic [7:0] b[256];
        for (int k = 0; k < 256; k++) begin
            b[k] = (k < 255) ? (8'(k) + seed) : 8'h00;
        end
        if (emit) begin
            for (int k = 0; k < 255; k++) begin
                exp_q.push_back({(k == 254), b[k]});
            end
        end
        apply_stimulus(marker, 1'b0);
        for (int w = 0; w < 64; w++) begin
            apply_stimulus({b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]}, chk_full && (w > 0));
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 3000) begin
            @(posedge core_clk);
            n++;
        end
        if (n >= 3000) begin
            report_fail("drain_timeout", 32'(exp_q.size()));
        end
        repeat (4) @(posedge core_clk);
        #1;
    endtask

    task automatic main_seq();
        row_t rows[13];
        int   e0;
        rows[0]  = '{SYNC,          8'h00, 1'b0, 0, 1'b1, 1'b1, 1};
        rows[1]  = '{SYNC,          8'h11, 1'b1, 0, 1'b1, 1'b1, -1};
        rows[2]  = '{32'h1ACFFC1E,  8'h22, 1'b0, 0, 1'b1, 1'b1, 3};
        rows[3]  = '{32'hFFFFFFFF,  8'h33, 1'b0, 1, 1'b1, 1'b1, 4};
        rows[4]  = '{32'hFFFFFFFF,  8'h44, 1'b0, 1, 1'b1, 1'b1, 5};
        rows[5]  = '{32'hFFFFFFFF,  8'h55, 1'b0, 1, 1'b0, 1'b0, 5};
        rows[6]  = '{32'h1ACFFC1C,  8'h66, 1'b0, 0, 1'b0, 1'b0, 5};
        rows[7]  = '{SYNC,          8'h77, 1'b0, 0, 1'b1, 1'b1, 6};
        rows[8]  = '{32'hFFFFFFFF,  8'h88, 1'b0, 1, 1'b1, 1'b1, 7};
        rows[9]  = '{32'h1ACFFC1C,  8'h99, 1'b0, 0, 1'b1, 1'b1, 8};
        rows[10] = '{32'hFFFFFFFF,  8'hAA, 1'b0, 1, 1'b1, 1'b1, 9};
        rows[11] = '{32'h1ACFFC1A,  8'hBB, 1'b0, 1, 1'b1, 1'b1, 10};
        rows[12] = '{SYNC,          8'hCC, 1'b0, 0, 1'b1, 1'b1, 11};

        // Reset values while rst is held.
        rst = 1'b1;
        repeat (3) @(posedge core_clk);
        #1;
        check_output("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_output("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check_output("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check_output("rst_locked", 32'(locked), 32'd0);
        check_output("rst_sync_err", 32'(sync_err), 32'd0);
        check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        @(negedge core_clk);
        rst = 1'b0;
        #1;
        check_output("release_tready", 32'(s_axis_tready), 32'd1);

        // Garbage, including a one-bit-off marker, never locks.
        apply_stimulus(32'hDEADBEEF, 1'b0);
        apply_stimulus(32'h1ACFFC1C, 1'b0);
        apply_stimulus(32'h00000000, 1'b0);
        s_axis_tvalid = 1'b0;
        repeat (3) @(posedge core_clk);
        #1;
        check_output("garbage_locked", 32'(locked), 32'd0);

        for (int r = 0; r < 13; r++) begin
            e0 = err_seen;
            send_frame(rows[r].marker, rows[r].seed, rows[r].exp_emit, 1'b0);
            if (!rows[r].b2b) begin
                wait_drain();
                check_output($sformatf("row%0d_frame_cnt", r), 32'(frame_cnt),
                             32'(rows[r].exp_cnt));
            end
            check_output($sformatf("row%0d_sync_err", r), 32'(err_seen - e0),
                         32'(rows[r].exp_err));
            check_output($sformatf("row%0d_locked", r), 32'(locked),
                         32'(rows[r].exp_locked));
        end

        // Downstream ready high one cycle in three for a whole frame.
        stall_mode = 1'b1;
        e0 = err_seen;
        send_frame(SYNC, 8'hDD, 1'b1, 1'b1);
        wait_drain();
        stall_mode = 1'b0;
        check_output("stall_frame_cnt", 32'(frame_cnt), 32'd12);
        check_output("stall_sync_err", 32'(err_seen - e0), 32'd0);

        // Reset while payload byte 100 is on the output.
        rx_count = 0;
        fork
            send_frame(SYNC, 8'h10, 1'b1, 1'b0);
            begin : rst_hit
                int n;
                n = 0;
                while (rx_count < 100 && n < 2000) begin
                    @(posedge core_clk);
                    n++;
                end
                if (rx_count < 100) begin
                    report_fail("rst_point_timeout", 32'(rx_count));
                end
                #1;
                rst = 1'b1;
                exp_q.delete();
                #1;
                check_output("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
                check_output("midrst_tlast", 32'(m_axis_tlast), 32'd0);
                check_output("midrst_tdata", 32'(m_axis_tdata), 32'd0);
                check_output("midrst_locked", 32'(locked), 32'd0);
                check_output("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
                repeat (3) @(posedge core_clk);
                @(negedge core_clk);
                rst = 1'b0;
            end
        join
        s_axis_tvalid = 1'b0;
        check_output("midrst_bytes_before", 32'(rx_count), 32'd100);
        wait_drain();
        check_output("after_rst_locked", 32'(locked), 32'd0);
        send_frame(SYNC, 8'h5A, 1'b1, 1'b0);
        wait_drain();
        check_output("relock_frame_cnt", 32'(frame_cnt), 32'd1);
        check_output("relock_locked", 32'(locked), 32'd1);
    endtask

    task automatic wrap_word(input logic [31:0] w, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        w_s_tdata  = w;
        w_s_tvalid = 1'b1;
        while (!ok && n < 50) begin
            @(negedge w_clk);
            if (w_s_tready) begin
                ok = 1'b1;
            end
            @(posedge w_clk);
            #1;
            n++;
        end
        if (!ok) begin
            report_fail("wrap_input_timeout", w);
        end
    endtask

    task automatic wrap_seq();
        bit ok1;
        bit ok2;
        bit alive;
        alive = 1'b1;
        w_rst = 1'b1;
        w_s_tvalid = 1'b0;
        w_s_tdata = '0;
        repeat (2) @(posedge w_clk);
        #1;
        w_rst = 1'b0;
        for (int i = 0; i < 65535 && alive; i++) begin
            wrap_word(SYNC, ok1);
            wrap_word(32'hAB000000, ok2);
            alive = ok1 && ok2;
        end
        w_s_tvalid = 1'b0;
        repeat (4) @(posedge w_clk);
        #1;
        check_output("wrap_cnt_ffff", 32'(w_frame_cnt), 32'h0000FFFF);
        check_output("wrap_locked", 32'(w_locked), 32'd1);
        wrap_word(SYNC, ok1);
        wrap_word(32'hAB000000, ok2);
        w_s_tvalid = 1'b0;
        repeat (4) @(posedge w_clk);
        #1;
        check_output("wrap_cnt_zero", 32'(w_frame_cnt), 32'd0);
    endtask

    initial begin
        #3000000;
        report_fail("watchdog", 32'(checks));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        err_seen      = 0;
        rx_count      = 0;
        stall_mode    = 1'b0;
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        $display("[TB] starting asm_deframer bench");
        fork
            main_seq();
            wrap_seq();
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
